sopc_cpu_mul_seq: RTL and testbench
===================================

# sopc_cpu_mul_seq

Multi-cycle multiply sequencer that sits directly upstream of the CPU multiply cell. Each call to the cell forms the low 32 bits of `src1 * src2[15:0]`. This block accepts one 32×32 multiply request, drives the cell for one or two passes, accumulates the partial results and returns the low 32 bits of the full product with a valid/ready handshake. The cell has one cycle of latency: operands driven in cycle t give `mul_cell_result` in cycle t+1.

## Interface
- `TAG_W`, default 5: width of the destination-register tag carried alongside the request.
- `FAST_ZERO`, default 1: when 1, skip pass 2 if `req_src2[31:16] == 0`.

- `clk`  in  1  single clock; all logic rises on it.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_src1`  in  32  multiplicand.
- `req_src2`  in  32  multiplier.
- `req_tag`  in  TAG_W  opaque tag, returned unchanged.
- `mul_src1`  out  32  operand A to the multiply cell.
- `mul_src2`  out  32  operand B to the multiply cell.
- `mul_cell_result`  in  32  cell output, valid one cycle after operands are driven.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  32  `(src1*src2) mod 2^32`.
- `rsp_tag`  out  TAG_W  tag of the request that produced `rsp_data`.

## Operation
- States: IDLE, P1, P2, SUM, DONE.
- IDLE
  - `req_ready` = 1.
  - On `req_valid`, latch src1, src2 and tag, then go to P1.
- P1
  - `mul_src1` = src1; `mul_src2` = src2.
  - If FAST_ZERO=1 and src2[31:16]==0, go to SUM with `fast` flag set; otherwise go to P2.
- P2
  - `mul_src1` = {src1[15:0], 16'h0}; `mul_src2` = {16'h0, src2[31:16]}. The cell then returns `(a_lo*b_hi)<<16` mod 2^32.
  - `acc` <= `mul_cell_result` (pass-1 result).
  - Go to SUM.
- SUM
  - `rsp_data` <= fast ? `mul_cell_result` : `acc + mul_cell_result`. The add is 32-bit and the carry out is discarded.
  - `rsp_tag` <= latched tag.
  - Go to DONE.
- DONE
  - `rsp_valid` = 1. `rsp_data` and `rsp_tag` stay stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- `mul_src1` and `mul_src2` are 0 in IDLE, SUM and DONE, which keeps the cell quiet.
- `req_ready` = 0 outside IDLE. Only one request is in flight; there is no queuing.
- Signed and unsigned inputs give identical low-32 results, so no sign handling is needed.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready` = 1, `rsp_valid` = 0.
  - `rsp_data` = 0, `rsp_tag` = 0.
  - `mul_src1` = `mul_src2` = 0.
  - `acc` = 0, `fast` = 0.
- Reset mid-operation: the next cycle is IDLE; the in-flight request is dropped and no response is produced.
- Acceptance occurs in cycle T. Response timing:
  - Full path: `rsp_valid` rises at T+4.
  - Fast path: `rsp_valid` rises at T+3.
- Pass 1 operands are driven at T+1; pass 2 operands at T+2 (full path only).
- Handshake completes at T+4 with `rsp_ready` held high. The earliest next acceptance is T+5, so maximum throughput is one request per 5 cycles (per 4 on the fast path).
- `req_valid` asserted outside IDLE is ignored. The requester must hold it until `req_ready`.
- Backpressure: DONE may last any number of cycles. `rsp_data` and `rsp_tag` must not change while `rsp_valid`=1 and `rsp_ready`=0.
- `rsp_valid` is never asserted while `req_ready`=1.

## Structure
- Shared CPU package holds:
  - the state enum (IDLE, P1, P2, SUM, DONE), 3-bit encoding;
  - a constant `MUL_CELL_LATENCY` = 1;
  - the `XLEN` = 32 width constant.
- Single module with no sub-module. The operand mux and FSM are small.
- The bench instantiates the real multiply cell downstream, so latency is checked end to end.

## Test plan
- Full path: src1=0x12345678, src2=0x9ABCDEF0, tag=7 -> `rsp_data`=0x242D2080, `rsp_tag`=7, `rsp_valid` at T+4.
- Fast path (FAST_ZERO=1): 0x0000FFFF × 0x00000003 -> 0x0002FFFD at T+3. Same operands with FAST_ZERO=0 -> same value at T+4.
- Wrap: 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000001. Also 0x80000000 × 0x00000002 -> 0x00000000.
- Backpressure: hold `rsp_ready`=0 for 6 cycles -> `rsp_data`/`rsp_tag` stable, `req_ready`=0 throughout, a second `req_valid` is ignored. Release -> IDLE the next cycle.
- Reset asserted in P2 -> next cycle IDLE, `rsp_valid` never rises, `mul_src1`/`mul_src2`=0. A following request 3 × 5 -> 15.
- Back-to-back random stream of 1000 ops with random `rsp_ready` -> every result equals the scoreboard `(a*b) mod 2^32` in order, with tags matching.

Source files
------------

// File: rtl/sopc_cpu_mul_seq_pkg.sv
// Shared CPU multiply definitions: datapath width, cell latency and sequencer state codes.
package sopc_cpu_mul_seq_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned MUL_CELL_LATENCY = 1;
    localparam int unsigned HALF             = XLEN / 2;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StP1   = 3'd1;
    localparam state_t StP2   = 3'd2;
    localparam state_t StSum  = 3'd3;
    localparam state_t StDone = 3'd4;

    // Pass 2 contributes nothing when the multiplier's upper half is zero.
    function automatic logic hi_half_zero(input logic [XLEN-1:0] src2);
        return src2[XLEN-1:HALF] == '0;
    endfunction

    function automatic logic [XLEN-1:0] pass2_src1(input logic [XLEN-1:0] src1);
        return {src1[HALF-1:0], {HALF{1'b0}}};
    endfunction

    function automatic logic [XLEN-1:0] pass2_src2(input logic [XLEN-1:0] src2);
        return {{HALF{1'b0}}, src2[XLEN-1:HALF]};
    endfunction

endpackage

// File: rtl/sopc_cpu_mul_seq_if.sv
// Request, response and multiply-cell signals of the multiply sequencer.
interface sopc_cpu_mul_seq_if #(
    parameter int unsigned TAG_W = 5
);
    import sopc_cpu_mul_seq_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_src1;
    logic [XLEN-1:0]  req_src2;
    logic [TAG_W-1:0] req_tag;

    logic [XLEN-1:0]  mul_src1;
    logic [XLEN-1:0]  mul_src2;
    logic [XLEN-1:0]  mul_cell_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    // Sequencer side.
    modport slave (
        input  req_valid, req_src1, req_src2, req_tag, mul_cell_result, rsp_ready,
        output req_ready, mul_src1, mul_src2, rsp_valid, rsp_data, rsp_tag
    );

    // Requester, multiply cell and response consumer side.
    modport master (
        output req_valid, req_src1, req_src2, req_tag, mul_cell_result, rsp_ready,
        input  req_ready, mul_src1, mul_src2, rsp_valid, rsp_data, rsp_tag
    );

endinterface

// File: rtl/sopc_cpu_mul_seq.sv
// Multi-cycle 32x32 multiply sequencer: drives a 32x16 multiply cell for one or two passes
// and returns the low 32 bits of the product over a valid/ready handshake.
module sopc_cpu_mul_seq
    import sopc_cpu_mul_seq_pkg::*;
#(
    parameter int unsigned TAG_W     = 5,
    parameter bit          FAST_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    sopc_cpu_mul_seq_if.slave   bus
);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  src1_q, src1_d;
    logic [XLEN-1:0]  src2_q, src2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic             fast_q, fast_d;
    logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    always_comb begin
        state_d    = state_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        tag_d      = tag_q;
        acc_d      = acc_q;
        fast_d     = fast_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    src1_d  = bus.req_src1;
                    src2_d  = bus.req_src2;
                    tag_d   = bus.req_tag;
                    fast_d  = 1'b0;
                    state_d = StP1;
                end
            end
            StP1: begin
                if (FAST_ZERO && hi_half_zero(src2_q)) begin
                    fast_d  = 1'b1;
                    state_d = StSum;
                end else begin
                    state_d = StP2;
                end
            end
            StP2: begin
                // Pass-1 result arrives now, one cycle after its operands.
                acc_d   = bus.mul_cell_result;
                state_d = StSum;
            end
            StSum: begin
                rsp_data_d = fast_q ? bus.mul_cell_result : acc_q + bus.mul_cell_result;
                rsp_tag_d  = tag_q;
                state_d    = StDone;
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operands are zero outside the two pass states so the cell stays quiet.
    always_comb begin
        bus.mul_src1 = '0;
        bus.mul_src2 = '0;
        case (state_q)
            StP1: begin
                bus.mul_src1 = src1_q;
                bus.mul_src2 = src2_q;
            end
            StP2: begin
                bus.mul_src1 = pass2_src1(src1_q);
                bus.mul_src2 = pass2_src2(src2_q);
            end
            default: begin
                bus.mul_src1 = '0;
                bus.mul_src2 = '0;
            end
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StDone);
        bus.rsp_data  = rsp_data_q;
        bus.rsp_tag   = rsp_tag_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            src1_q     <= '0;
            src2_q     <= '0;
            tag_q      <= '0;
            acc_q      <= '0;
            fast_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            tag_q      <= tag_d;
            acc_q      <= acc_d;
            fast_q     <= fast_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
        end
    end

endmodule

// File: tb/tb_sopc_cpu_mul_seq.sv
// Bench for sopc_cpu_mul_seq with a behavioural one-cycle multiply cell downstream.
module tb_sopc_cpu_mul_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sopc_cpu_mul_seq_if #(.TAG_W(5)) bus ();
    sopc_cpu_mul_seq_if #(.TAG_W(5)) bus_nf ();

    sopc_cpu_mul_seq #(.TAG_W(5), .FAST_ZERO(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sopc_cpu_mul_seq #(.TAG_W(5), .FAST_ZERO(1'b0)) u_dut_nf (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nf)
    );

    // Multiply cells: low 32 bits of src1 * src2[15:0], one cycle latency.
    logic [31:0] cell_q, cell_nf_q;
    always_ff @(posedge clk) begin
        cell_q    <= bus.mul_src1 * {16'h0, bus.mul_src2[15:0]};
        cell_nf_q <= bus_nf.mul_src1 * {16'h0, bus_nf.mul_src2[15:0]};
    end
    assign bus.mul_cell_result    = cell_q;
    assign bus_nf.mul_cell_result = cell_nf_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for req_ready, then present the request for exactly one accepting cycle.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int n;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_before_accept", {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_src1  = a;
        bus.req_src2  = b;
        bus.req_tag   = tag;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Called one cycle after acceptance; returns cycles from acceptance to rsp_valid.
    task automatic wait_rsp(input logic [31:0] a, input logic [31:0] b, input bit full,
                            output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            if (lat == 1) begin
                chk("p1_src1", bus.mul_src1, a);
                chk("p1_src2", bus.mul_src2, b);
            end
            if (lat == 2 && full) begin
                chk("p2_src1", bus.mul_src1, {a[15:0], 16'h0});
                chk("p2_src2", bus.mul_src2, {16'h0, b[31:16]});
            end
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        accept(v.a, v.b, v.tag);
        wait_rsp(v.a, v.b, v.lat == 4, lat);
        chk("latency", lat, v.lat);
        chk("rsp_data", bus.rsp_data, v.exp);
        chk("rsp_tag", {27'b0, bus.rsp_tag}, {27'b0, v.tag});
        chk("req_ready_in_done", {31'b0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("idle_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    endtask

    vec_t vecs[7];
    rsp_t exp_q[$];

    initial begin
        int   lat;
        bit   seen;
        int   got;
        int   cyc;

        vecs[0] = '{a: 32'h12345678, b: 32'h9ABCDEF0, tag: 5'd7,  exp: 32'h242D2080, lat: 4};
        vecs[1] = '{a: 32'h0000FFFF, b: 32'h00000003, tag: 5'd1,  exp: 32'h0002FFFD, lat: 3};
        vecs[2] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, tag: 5'd2,  exp: 32'h00000001, lat: 4};
        vecs[3] = '{a: 32'h80000000, b: 32'h00000002, tag: 5'd3,  exp: 32'h00000000, lat: 3};
        vecs[4] = '{a: 32'h00010000, b: 32'h00010000, tag: 5'd31, exp: 32'h00000000, lat: 4};
        vecs[5] = '{a: 32'h0000FFFF, b: 32'h00010001, tag: 5'd16, exp: 32'hFFFFFFFF, lat: 4};
        vecs[6] = '{a: 32'h00000003, b: 32'h00000005, tag: 5'd9,  exp: 32'h0000000F, lat: 3};

        bus.req_valid    = 1'b0;
        bus.req_src1     = '0;
        bus.req_src2     = '0;
        bus.req_tag      = '0;
        bus.rsp_ready    = 1'b0;
        bus_nf.req_valid = 1'b0;
        bus_nf.req_src1  = '0;
        bus_nf.req_src2  = '0;
        bus_nf.req_tag   = '0;
        bus_nf.rsp_ready = 1'b0;

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_tag", {27'b0, bus.rsp_tag}, 32'd0);
        chk("rst_mul_src1", bus.mul_src1, 32'd0);
        chk("rst_mul_src2", bus.mul_src2, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Fast-path operands on the instance without the shortcut take the full four cycles.
        bus_nf.req_valid = 1'b1;
        bus_nf.req_src1  = 32'h0000FFFF;
        bus_nf.req_src2  = 32'h00000003;
        bus_nf.req_tag   = 5'd4;
        tick();
        bus_nf.req_valid = 1'b0;
        lat = 1;
        while (!bus_nf.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("nf_latency", lat, 4);
        chk("nf_rsp_data", bus_nf.rsp_data, 32'h0002FFFD);
        chk("nf_rsp_tag", {27'b0, bus_nf.rsp_tag}, 32'd4);
        bus_nf.rsp_ready = 1'b1;
        tick();
        bus_nf.rsp_ready = 1'b0;

        // Backpressure: response held, a competing request ignored.
        accept(32'h12345678, 32'h9ABCDEF0, 5'd7);
        wait_rsp(32'h12345678, 32'h9ABCDEF0, 1'b1, lat);
        chk("bp_latency", lat, 4);
        bus.req_valid = 1'b1;
        bus.req_src1  = 32'h00000002;
        bus.req_src2  = 32'h00000002;
        bus.req_tag   = 5'd12;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_rsp_data", bus.rsp_data, 32'h242D2080);
            chk("bp_rsp_tag", {27'b0, bus.rsp_tag}, 32'd7);
            chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
            chk("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_release_idle", {31'b0, bus.req_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("bp_ignored_req", {31'b0, seen}, 32'd0);

        // Reset while in P2 drops the request.
        accept(32'h12345678, 32'h9ABCDEF0, 5'd5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_mul_src1", bus.mul_src1, 32'd0);
        chk("rst_mid_mul_src2", bus.mul_src2, 32'd0);
        chk("rst_mid_rsp_data", bus.rsp_data, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("rst_mid_no_rsp", {31'b0, seen}, 32'd0);
        run_vec(vecs[6]);

        // Random stream with random consumer backpressure, checked against a scoreboard.
        got = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [31:0] a;
                    logic [31:0] b;
                    logic [4:0]  t;
                    int          n;
                    a = $urandom;
                    b = $urandom;
                    t = 5'($urandom);
                    if ($urandom_range(3) == 0) b[31:16] = 16'h0;
                    n = 0;
                    while (!bus.req_ready && n < 100) begin
                        tick();
                        n++;
                    end
                    if (!bus.req_ready) begin
                        chk("stream_accept_timeout", {31'b0, bus.req_ready}, 32'd1);
                        break;
                    end
                    bus.req_valid = 1'b1;
                    bus.req_src1  = a;
                    bus.req_src2  = b;
                    bus.req_tag   = t;
                    exp_q.push_back('{data: a * b, tag: t});
                    tick();
                    bus.req_valid = 1'b0;
                end
            end
            begin
                cyc = 0;
                while (got < 1000 && cyc < 40000) begin
                    logic r;
                    tick();
                    cyc++;
                    r = ($urandom_range(3) != 0);
                    bus.rsp_ready = r;
                    if (bus.rsp_valid && r) begin
                        if (exp_q.size() == 0) begin
                            chk("stream_unexpected_rsp", 32'd1, 32'd0);
                        end else begin
                            rsp_t e;
                            e = exp_q.pop_front();
                            chk("stream_data", bus.rsp_data, e.data);
                            chk("stream_tag", {27'b0, bus.rsp_tag}, {27'b0, e.tag});
                        end
                        got++;
                    end
                end
                bus.rsp_ready = 1'b0;
            end
        join
        chk("stream_count", got, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
